// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling enable derived from baud_clk.
// Deframes LSB-first bytes and flags frames whose stop bit samples low.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16,
  parameter int CNT_W     = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 baud_clk,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OS_RATE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OS_RATE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, err_next;
  logic                 baud_d, sync_1, rxd_s, last_sample;
  logic                 tick;

  // baud_clk is only ever a clock-enable source: one tick per rising edge.
  assign tick = baud_clk & ~baud_d;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      baud_d       <= 1'b0;
      sync_1       <= 1'b1;
      rxd_s        <= 1'b1;
      last_sample  <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      baud_d       <= baud_clk;
      sync_1       <= uart_rxd;
      rxd_s        <= sync_1;
      if (tick)
        last_sample <= rxd_s;
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift_reg    <= shift_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_frame_err <= err_next;
      rx_busy      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    data_next    = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          // Falling edge only, so a held-low break cannot retrigger a frame.
          if (!rxd_s && last_sample) begin
            state_next = START;
            cnt_next   = '0;
          end
        end
        START: begin
          if (cnt == MID_CNT) begin
            cnt_next = '0;
            if (!rxd_s) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            shift_next   = {rxd_s, shift_reg[DATA_BITS-1:1]};
            cnt_next     = '0;
            bit_idx_next = bit_idx + IDX_W'(1);
            if (bit_idx == LAST_BIT)
              state_next = STOP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt_next   = '0;
            state_next = IDLE;
            if (rxd_s) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule
